// File: rtl/epu_pkg.sv
// Shared RV32I decode types for the EPU pipeline: op enum, opcode constants,
// immediate formats and the immediate extraction helper.
package epu_pkg;

  localparam int PC_W = 32;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ZeroWord = '0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    imm = ZeroWord;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = ZeroWord;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of the fetch, register-file and execute-side signals of id_stage.
// Modport master is the decode stage's view; slave is the surrounding pipeline.
interface id_stage_if;

  logic               rdy_in;
  logic               flush_in;
  logic               if_valid_in;
  logic               if_ready_out;
  logic [31:0]        if_pc_in;
  logic [31:0]        if_inst_in;
  logic               rf_read_flag_1_out;
  logic [4:0]         rf_reg_read_1_out;
  logic [31:0]        rf_data_1_in;
  logic               rf_read_flag_2_out;
  logic [4:0]         rf_reg_read_2_out;
  logic [31:0]        rf_data_2_in;
  logic               ex_busy_in;
  logic [4:0]         ex_busy_rd_in;
  logic               ex_busy_load_in;
  logic [31:0]        ex_fwd_data_in;
  logic               ex_valid_out;
  logic               ex_ready_in;
  logic [31:0]        ex_pc_out;
  epu_pkg::op_e       ex_op_out;
  logic [31:0]        ex_rs1_data_out;
  logic [31:0]        ex_rs2_data_out;
  logic [31:0]        ex_imm_out;
  logic [4:0]         ex_rd_out;
  logic               ex_wen_out;
  logic               ex_illegal_out;

  modport master (
    input  rdy_in, flush_in, if_valid_in, if_pc_in, if_inst_in,
    input  rf_data_1_in, rf_data_2_in,
    input  ex_busy_in, ex_busy_rd_in, ex_busy_load_in, ex_fwd_data_in, ex_ready_in,
    output if_ready_out, rf_read_flag_1_out, rf_reg_read_1_out,
    output rf_read_flag_2_out, rf_reg_read_2_out,
    output ex_valid_out, ex_pc_out, ex_op_out, ex_rs1_data_out, ex_rs2_data_out,
    output ex_imm_out, ex_rd_out, ex_wen_out, ex_illegal_out
  );

  modport slave (
    output rdy_in, flush_in, if_valid_in, if_pc_in, if_inst_in,
    output rf_data_1_in, rf_data_2_in,
    output ex_busy_in, ex_busy_rd_in, ex_busy_load_in, ex_fwd_data_in, ex_ready_in,
    input  if_ready_out, rf_read_flag_1_out, rf_reg_read_1_out,
    input  rf_read_flag_2_out, rf_reg_read_2_out,
    input  ex_valid_out, ex_pc_out, ex_op_out, ex_rs1_data_out, ex_rs2_data_out,
    input  ex_imm_out, ex_rd_out, ex_wen_out, ex_illegal_out
  );

endinterface

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: instruction word to op, immediate, rd/wen and
// source-usage flags. Anything outside the 37 base ops decodes as illegal NOP.
module id_decoder
  import epu_pkg::*;
(
  input  logic [31:0] inst,
  output op_e         op,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        wen,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_e   fmt;
  logic       has_rd;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    op      = OP_NOP;
    fmt     = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin op = OP_LUI;   fmt = IMM_U; has_rd = 1'b1; end
      OPC_AUIPC: begin op = OP_AUIPC; fmt = IMM_U; has_rd = 1'b1; end
      OPC_JAL:   begin op = OP_JAL;   fmt = IMM_J; has_rd = 1'b1; end
      OPC_JALR: begin
        op = OP_JALR; fmt = IMM_I; has_rd = 1'b1; use_rs1 = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I; use_rs1 = 1'b1; has_rd = 1'b1;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; use_rs1 = 1'b1; has_rd = 1'b1;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: if (f7 == 7'h00) op = OP_SLLI; else illegal = 1'b1;
          default: begin
            if (f7 == 7'h00)      op = OP_SRLI;
            else if (f7 == 7'h20) op = OP_SRAI;
            else                  illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: op = OP_ADD;
          {7'h20, 3'b000}: op = OP_SUB;
          {7'h00, 3'b001}: op = OP_SLL;
          {7'h00, 3'b010}: op = OP_SLT;
          {7'h00, 3'b011}: op = OP_SLTU;
          {7'h00, 3'b100}: op = OP_XOR;
          {7'h00, 3'b101}: op = OP_SRL;
          {7'h20, 3'b101}: op = OP_SRA;
          {7'h00, 3'b110}: op = OP_OR;
          {7'h00, 3'b111}: op = OP_AND;
          default:         illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word must not read or write anything downstream.
    if (illegal) begin
      op      = OP_NOP;
      fmt     = IMM_NONE;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      has_rd  = 1'b0;
    end
  end

  assign imm = imm_gen(inst, fmt);
  assign rd  = has_rd ? inst[11:7] : 5'd0;
  assign wen = has_rd & (inst[11:7] != 5'd0);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: one-entry decode slot, RAW hazard stall and a registered
// operand packet to execute. Define ID_STAGE_FWD_EN to forward non-load execute results.
module id_stage
  import epu_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_n_in,
  id_stage_if.master bus
);

  logic            slot_valid_reg;
  logic [PC_W-1:0] slot_pc_reg;
  logic [31:0]     slot_inst_reg;

  logic            ex_valid_reg;
  logic [PC_W-1:0] ex_pc_reg;
  op_e             ex_op_reg;
  logic [31:0]     ex_rs1_reg;
  logic [31:0]     ex_rs2_reg;
  logic [31:0]     ex_imm_reg;
  logic [4:0]      ex_rd_reg;
  logic            ex_wen_reg;
  logic            ex_illegal_reg;

  op_e         dec_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_wen;
  logic        dec_illegal;
  logic [1:0]  use_rs;

  id_decoder u_decoder (
    .inst    (slot_inst_reg),
    .op      (dec_op),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .wen     (dec_wen),
    .use_rs1 (use_rs[0]),
    .use_rs2 (use_rs[1]),
    .illegal (dec_illegal)
  );

  logic [4:0]  rs_idx  [2];
  logic [31:0] rf_data [2];
  logic [31:0] operand [2];
  logic [1:0]  src_live;
  logic [1:0]  haz_out;
  logic [1:0]  haz_ex;
  logic        stall;
  logic        advance;
  logic        if_ready;
  logic        accept;

  assign rs_idx[0]  = slot_inst_reg[19:15];
  assign rs_idx[1]  = slot_inst_reg[24:20];
  assign rf_data[0] = bus.rf_data_1_in;
  assign rf_data[1] = bus.rf_data_2_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_live[gi] = slot_valid_reg & use_rs[gi] & (rs_idx[gi] != 5'd0);
      assign haz_out[gi]  = src_live[gi] & ex_valid_reg & ex_wen_reg & (ex_rd_reg == rs_idx[gi]);
      assign haz_ex[gi]   = src_live[gi] & bus.ex_busy_in & (bus.ex_busy_rd_in == rs_idx[gi]);
`ifdef ID_STAGE_FWD_EN
      assign operand[gi]  = haz_ex[gi] ? bus.ex_fwd_data_in : rf_data[gi];
`else
      assign operand[gi]  = rf_data[gi];
`endif
    end
  endgenerate

`ifdef ID_STAGE_FWD_EN
  // Output-register producers have no result yet; only loads hold up an execute match.
  assign stall = (|haz_out) | ((|haz_ex) & bus.ex_busy_load_in);
`else
  assign stall = (|haz_out) | (|haz_ex);
`endif

  assign advance  = slot_valid_reg & ~stall & (~ex_valid_reg | bus.ex_ready_in) & bus.rdy_in;
  assign if_ready = rst_n_in & bus.rdy_in & (~slot_valid_reg | advance);
  assign accept   = bus.if_valid_in & if_ready & ~bus.flush_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_valid_reg <= 1'b0;
      slot_pc_reg    <= '0;
      slot_inst_reg  <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        slot_valid_reg <= 1'b0;
      end else if (accept) begin
        slot_valid_reg <= 1'b1;
        slot_pc_reg    <= bus.if_pc_in;
        slot_inst_reg  <= bus.if_inst_in;
      end else if (advance) begin
        slot_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= '0;
      ex_op_reg      <= OP_NOP;
      ex_rs1_reg     <= ZeroWord;
      ex_rs2_reg     <= ZeroWord;
      ex_imm_reg     <= ZeroWord;
      ex_rd_reg      <= 5'd0;
      ex_wen_reg     <= 1'b0;
      ex_illegal_reg <= 1'b0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        ex_valid_reg <= 1'b0;
      end else if (advance) begin
        ex_valid_reg   <= 1'b1;
        ex_pc_reg      <= slot_pc_reg;
        ex_op_reg      <= dec_op;
        ex_rs1_reg     <= operand[0];
        ex_rs2_reg     <= operand[1];
        ex_imm_reg     <= dec_imm;
        ex_rd_reg      <= dec_rd;
        ex_wen_reg     <= dec_wen;
        ex_illegal_reg <= dec_illegal;
      end else if (bus.ex_ready_in) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.if_ready_out       = if_ready;
  assign bus.rf_read_flag_1_out = slot_valid_reg & use_rs[0];
  assign bus.rf_reg_read_1_out  = rs_idx[0];
  assign bus.rf_read_flag_2_out = slot_valid_reg & use_rs[1];
  assign bus.rf_reg_read_2_out  = rs_idx[1];
  assign bus.ex_valid_out       = ex_valid_reg;
  assign bus.ex_pc_out          = ex_pc_reg;
  assign bus.ex_op_out          = ex_op_reg;
  assign bus.ex_rs1_data_out    = ex_rs1_reg;
  assign bus.ex_rs2_data_out    = ex_rs2_reg;
  assign bus.ex_imm_out         = ex_imm_reg;
  assign bus.ex_rd_out          = ex_rd_reg;
  assign bus.ex_wen_out         = ex_wen_reg;
  assign bus.ex_illegal_out     = ex_illegal_reg;

endmodule
